// File: rtl/button_conditioner.sv
// Push-button front-end: per channel a 2-flop synchronizer, a counter-based
// debouncer, single-cycle press/release pulses and, for channels selected by
// REPEAT_MASK, hold-to-repeat step pulses.
//
// Optional feature macro: BUTTON_AUTOREPEAT_EN
//   defined   - repeat FSMs/counters are built for channels with REPEAT_MASK bit set
//   undefined - no repeat logic; btn_step_o == btn_press_o on every channel
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   btn_in_i       raw asynchronous button pins, active-high
//   btn_level_o    debounced level
//   btn_press_o    1-cycle pulse on debounced rising edge
//   btn_release_o  1-cycle pulse on debounced falling edge
//   btn_step_o     press pulse OR repeat tick
module button_conditioner #(
  parameter int unsigned         CLK_FREQ        = 100_000_000,
  parameter int unsigned         NUM_BTN         = 5,
  parameter int unsigned         DEBOUNCE_MS     = 10,
  parameter int unsigned         REPEAT_DELAY_MS = 500,
  parameter int unsigned         REPEAT_RATE_MS  = 100,
  parameter logic [NUM_BTN-1:0]  REPEAT_MASK     = NUM_BTN'(5'b00010)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_in_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic [NUM_BTN-1:0] btn_step_o
);

  localparam int unsigned CycPerMs = CLK_FREQ / 1000;
  localparam int unsigned Db       = CycPerMs * DEBOUNCE_MS;
  localparam int unsigned Rd       = CycPerMs * REPEAT_DELAY_MS;
  localparam int unsigned Rr       = CycPerMs * REPEAT_RATE_MS;
  localparam int unsigned MaxDbRd  = (Db > Rd) ? Db : Rd;
  localparam int unsigned MaxCnt   = (MaxDbRd > Rr) ? MaxDbRd : Rr;
  localparam int unsigned CntW     = $clog2(MaxCnt) + 1;

`ifdef BUTTON_AUTOREPEAT_EN
  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;
`endif

  logic [NUM_BTN-1:0] s1_q;
  logic [NUM_BTN-1:0] s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_in_i;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic            stable_q;
    logic            stable_dly_q;
    logic [CntW-1:0] cnt_q;
    logic            press;
    logic            tick;

    // Count consecutive cycles where the synchronized input differs from the
    // accepted level; any return to the accepted level restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stable_q     <= 1'b0;
        stable_dly_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        stable_dly_q <= stable_q;
        if (s2_q[i] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntW'(Db - 1)) begin
          stable_q <= s2_q[i];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end

    assign press            = stable_q & ~stable_dly_q;
    assign btn_level_o[i]   = stable_q;
    assign btn_press_o[i]   = press;
    assign btn_release_o[i] = ~stable_q & stable_dly_q;
    assign btn_step_o[i]    = press | tick;

    if (REPEAT_MASK[i]) begin : g_rep
`ifdef BUTTON_AUTOREPEAT_EN
      rep_state_e      state_q;
      logic [CntW-1:0] rcnt_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= StIdle;
          rcnt_q  <= '0;
        end else if (!stable_q) begin
          state_q <= StIdle;
          rcnt_q  <= '0;
        end else begin
          unique case (state_q)
            StIdle: begin
              if (press) begin
                state_q <= StDelay;
                rcnt_q  <= '0;
              end
            end
            StDelay: begin
              if (rcnt_q == CntW'(Rd - 1)) begin
                state_q <= StRepeat;
                rcnt_q  <= '0;
              end else begin
                rcnt_q <= rcnt_q + CntW'(1);
              end
            end
            StRepeat: begin
              if (rcnt_q == CntW'(Rr - 1)) begin
                rcnt_q <= '0;
              end else begin
                rcnt_q <= rcnt_q + CntW'(1);
              end
            end
            default: begin
              state_q <= StIdle;
              rcnt_q  <= '0;
            end
          endcase
        end
      end

      // Gated by the live level so no tick lands on the release cycle.
      assign tick = stable_q &
                    (((state_q == StDelay)  && (rcnt_q == CntW'(Rd - 1))) ||
                     ((state_q == StRepeat) && (rcnt_q == CntW'(Rr - 1))));
`else
      assign tick = 1'b0;
`endif
    end else begin : g_norep
      assign tick = 1'b0;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB=4, RD=10, RR=3.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] btn_in;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic [4:0] btn_step;

  int n_chk = 0;
  int n_err = 0;

  button_conditioner #(
    .CLK_FREQ        (1000),
    .NUM_BTN         (5),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (10),
    .REPEAT_RATE_MS  (3),
    .REPEAT_MASK     (5'b00010)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .btn_in_i      (btn_in),
    .btn_level_o   (btn_level),
    .btn_press_o   (btn_press),
    .btn_release_o (btn_release),
    .btn_step_o    (btn_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   {3'b0, btn_level},   8'h00);
    check({tag, "_press"},   {3'b0, btn_press},   8'h00);
    check({tag, "_release"}, {3'b0, btn_release}, 8'h00);
    check({tag, "_step"},    {3'b0, btn_step},    8'h00);
  endtask

  task automatic cycles(input int n);
    for (int j = 0; j < n; j++) @(negedge clk);
  endtask

  initial begin
    logic exp_lvl;
    logic exp_stp;
    logic [7:0] bpat;

    rst    = 1'b1;
    btn_in = 5'b0;
    cycles(2);
    check_all_zero("reset");
    rst = 1'b0;
    cycles(3);
    check_all_zero("idle");

    // Clean press on channel 0: level rises 6 negedges after driving.
    btn_in[0] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("ch0_pre_level", {7'b0, btn_level[0]}, 8'h00);
      check("ch0_pre_press", {7'b0, btn_press[0]}, 8'h00);
    end
    @(negedge clk);
    check("ch0_level", {7'b0, btn_level[0]}, 8'h01);
    check("ch0_press", {7'b0, btn_press[0]}, 8'h01);
    check("ch0_step",  {7'b0, btn_step[0]},  8'h01);
    @(negedge clk);
    check("ch0_press_once", {7'b0, btn_press[0]}, 8'h00);
    check("ch0_level_hold", {7'b0, btn_level[0]}, 8'h01);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      check("ch0_no_repeat", {7'b0, btn_step[0]}, 8'h00);
    end
    btn_in[0] = 1'b0;
    cycles(5);
    check("ch0_rel_early", {7'b0, btn_release[0]}, 8'h00);
    @(negedge clk);
    check("ch0_release",  {7'b0, btn_release[0]}, 8'h01);
    check("ch0_level_lo", {7'b0, btn_level[0]},   8'h00);
    cycles(3);

    // Bounce on channel 2: 3 high, 1 low, 3 high, then low.
    bpat = 8'b0111_0111;
    for (int j = 0; j < 8; j++) begin
      btn_in[2] = bpat[j];
      @(negedge clk);
      check("ch2_bounce", {5'b0, btn_level[2], btn_press[2], btn_release[2]}, 8'h00);
    end
    btn_in[2] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("ch2_bounce_tail", {5'b0, btn_level[2], btn_press[2], btn_release[2]}, 8'h00);
    end

    // Simultaneous press on channels 3 and 4 (no repeat on either).
    btn_in[4:3] = 2'b11;
    cycles(6);
    check("ch34_press", {6'b0, btn_press[4:3]}, 8'h03);
    check("ch34_step",  {6'b0, btn_step[4:3]},  8'h03);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      check("ch34_no_repeat", {6'b0, btn_step[4:3]},  8'h00);
      check("ch34_level",     {6'b0, btn_level[4:3]}, 8'h03);
    end
    btn_in[4:3] = 2'b00;
    cycles(10);

    // Hold-to-repeat on channel 1; input dropped at offset 25 so the level
    // falls at offset 31, a slot where a tick would otherwise be due.
    btn_in[1] = 1'b1;
    cycles(6);
    check("ch1_press", {7'b0, btn_press[1]}, 8'h01);
    check("ch1_step0", {7'b0, btn_step[1]},  8'h01);
    for (int off = 1; off <= 35; off++) begin
      @(negedge clk);
      exp_lvl = (off <= 30);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_stp = exp_lvl && (off >= 10) && (((off - 10) % 3) == 0);
`else
      exp_stp = 1'b0;
`endif
      check("ch1_rep_step",    {7'b0, btn_step[1]},    {7'b0, exp_stp});
      check("ch1_rep_level",   {7'b0, btn_level[1]},   {7'b0, exp_lvl});
      check("ch1_rep_release", {7'b0, btn_release[1]}, {7'b0, (off == 31)});
      check("ch1_rep_press",   {7'b0, btn_press[1]},   8'h00);
      if (off == 25) btn_in[1] = 1'b0;
    end
    cycles(4);

    // Reset while channel 1 is held in the repeat phase.
    btn_in[1] = 1'b1;
    cycles(20);
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_hold1");
    @(negedge clk);
    check_all_zero("rst_hold2");
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("rst_pre_press", {7'b0, btn_press[1]}, 8'h00);
      check("rst_pre_level", {7'b0, btn_level[1]}, 8'h00);
    end
    @(negedge clk);
    check("rst_repress",  {7'b0, btn_press[1]}, 8'h01);
    check("rst_restep",   {7'b0, btn_step[1]},  8'h01);
    for (int off = 1; off <= 12; off++) begin
      @(negedge clk);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_stp = (off == 10);
`else
      exp_stp = 1'b0;
`endif
      check("rst_restart_step", {7'b0, btn_step[1]}, {7'b0, exp_stp});
    end
    btn_in[1] = 1'b0;
    cycles(8);
    check_all_zero("final_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the board push-buttons (BTNC/BTNU/BTNL/BTNR/BTND) ahead of the clock top-level's mode/select/increment logic.
- Per channel it provides:
  - a 2-flop synchronizer
  - a counter-based debouncer
  - single-cycle press and release pulses
  - for masked channels, hold-to-repeat step pulses, so holding BTNU advances a digit at a fixed rate.
- Replaces ad-hoc previous-value edge detection on raw pins.

Parameters:
- CLK_FREQ, 100_000_000, clk frequency in Hz; must be a multiple of 1000.
- NUM_BTN, 5, number of button channels. Index map: 0=BTNC, 1=BTNU, 2=BTNL, 3=BTNR, 4=BTND.
- DEBOUNCE_MS, 10, stable time required before a level change is accepted.
- REPEAT_DELAY_MS, 500, hold time from press to first repeat step.
- REPEAT_RATE_MS, 100, period of subsequent repeat steps.
- REPEAT_MASK, 5'b00010, per-channel auto-repeat enable (default: BTNU only).

Ports:
- clk, input, 1, system clock.
- reset, input, 1. Asynchronous, active-high reset.
- btn_in, input, NUM_BTN, raw asynchronous button pins, active-high.
- btn_level, output, NUM_BTN, debounced level.
- btn_press, output, NUM_BTN, 1-cycle pulse on debounced rising edge.
- btn_release, output, NUM_BTN, 1-cycle pulse on debounced falling edge.
- btn_step, output, NUM_BTN, btn_press OR repeat tick.

Behaviour:
Constants:
- DB = CLK_FREQ/1000*DEBOUNCE_MS, RD = CLK_FREQ/1000*REPEAT_DELAY_MS, RR = CLK_FREQ/1000*REPEAT_RATE_MS; each must be at least 1.
- Counter width is $clog2 of the largest constant plus 1.

Reset:
- Reset asserted: all synchronizer flops, stable levels, counters and FSMs are cleared to 0/IDLE immediately; every output is 0.
- A button held through reset deassertion is treated as a new press after the normal debounce latency.

Synchronizer: s1 <= btn_in, s2 <= s1.

Debounce, per channel:
- If s2 == stable: cnt <= 0.
- Else if cnt == DB-1: stable <= s2, cnt <= 0.
- Else: cnt <= cnt+1.
- Any bounce back to the stable value before DB consecutive differing cycles restarts the count; no output activity.
- Latency: if btn_in is first sampled high at edge k and held, btn_level goes high after edge k+DB+1. Falling latency is identical.

Edges:
- btn_press = stable & ~stable_d and btn_release = ~stable & stable_d, where stable_d is stable delayed one cycle.
- Each is high for exactly the first cycle of the new btn_level value.

Repeat FSM, per channel with REPEAT_MASK bit = 1. States IDLE, DELAY, REPEAT:
- IDLE -> DELAY on btn_press, rcnt <= 0.
- DELAY: rcnt increments. When rcnt == RD-1, emit tick, go to REPEAT, rcnt <= 0. The first tick is RD cycles after the press pulse.
- REPEAT: tick every RR cycles (rcnt wraps at RR-1).
- Any state -> IDLE when btn_level == 0. No tick is issued in the cycle btn_level reads 0; the release pulse and a tick never coincide.
- Channels with mask bit 0 stay in IDLE; their btn_step == btn_press.

Output and channel rules:
- btn_step = btn_press | tick. press and tick are mutually exclusive by construction.
- All channels are independent. Simultaneous presses on several channels produce simultaneous pulses.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined: the repeat FSMs and counters are built per REPEAT_MASK as above.
- Undefined: no repeat logic is synthesized, REPEAT_* parameters are ignored, and btn_step is wired to btn_press for all channels.

Test Plan:
All tests use CLK_FREQ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3, giving DB=4, RD=10, RR=3.
- Clean press: btn_in[0] driven 0->1 and sampled high at edge k, then held -> btn_level[0]=1 after edge k+5; btn_press[0] high exactly 1 cycle; btn_step[0] equals press; no repeat.
- Bounce: btn_in[2] toggles high for 3 cycles, low for 1, high for 3, then low -> btn_level, btn_press and btn_release on channel 2 stay 0 throughout.
- Hold repeat: btn_in[1] held for 30 cycles after its press pulse (macro defined) -> btn_step[1] pulses at press+0, +10, +13, +16, ..., +28; btn_release[1] follows after debounce with no step in that cycle.
- Simultaneous: btn_in[3] and btn_in[4] rise on the same edge -> btn_press[3] and btn_press[4] in the same cycle; no repeat on either (mask 0).
- Reset mid-hold: channel 1 in REPEAT, reset pulsed for 2 cycles while btn_in[1] is held -> all outputs 0 during reset; after release, btn_press[1] is re-issued at DB+2 edges, and the repeat sequence restarts from DELAY.
- Macro off: rerun the hold-repeat scenario -> btn_step[1] pulses once only, coincident with btn_press[1].
